verbus_sram_controller: RTL and testbench



---
 rtl/verbus_mem_pkg.sv | 25 ++
 rtl/verbus_sram_model.sv | 46 ++++
 rtl/verbus_sram_controller.sv | 142 ++++++++++++++
 tb/tb_verbus_sram_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/verbus_mem_pkg.sv
// ----------------------------------------------------------------------------
// verbus_mem_pkg: shared types and helpers for the verbus SRAM slave
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package verbus_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_e;

  localparam logic [3:0] WSTROBE_NONE = 4'b0000;

  function automatic logic [31:0] word_index(input logic [31:0] address,
                                             input logic [31:0] base);
    return (address - base) >> 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/verbus_sram_model.sv
// ----------------------------------------------------------------------------
// verbus_sram_model: behavioural byte-write synchronous SRAM, fixed read latency
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module verbus_sram_model
  import verbus_mem_pkg::*;
#(
  parameter  int SIZE_WORDS   = 4096,
  parameter  int READ_LATENCY = 1,
  localparam int AW           = $clog2(SIZE_WORDS)
) (
  input  logic          clk,
  input  logic          mem_en,
  input  logic [3:0]    mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_wdata,
  output logic [31:0]   mem_rdata
);

  logic [31:0] mem_q  [SIZE_WORDS];
  logic [31:0] pipe_q [READ_LATENCY];
  logic [31:0] merged;

  always_comb begin
    merged = mem_q[mem_addr];
    for (int b = 0; b < 4; b++) begin
      if (mem_we[b]) merged[8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  // Read returns the pre-write contents when a write and read share a strobe.
  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we != WSTROBE_NONE) mem_q[mem_addr] <= merged;
      pipe_q[0] <= mem_q[mem_addr];
    end
    for (int i = READ_LATENCY - 1; i > 0; i--) pipe_q[i] <= pipe_q[i-1];
  end

  assign mem_rdata = pipe_q[READ_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/verbus_sram_controller.sv
// ----------------------------------------------------------------------------
// verbus_sram_controller: valid/ready bus slave driving a single-port sync SRAM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module verbus_sram_controller
  import verbus_mem_pkg::*;
#(
  parameter  int          SIZE_WORDS   = 4096,
  parameter  logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter  int          READ_LATENCY = 1,
  parameter  int          WAIT_STATES  = 0,
  localparam int          AW           = $clog2(SIZE_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          valid,
  output logic          ready,
  input  logic [31:0]   address,
  input  logic [3:0]    wstrobe,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [32:0] WINDOW_BYTES  = 33'(SIZE_WORDS) << 2;
  localparam logic [3:0]  READ_COUNT    = 4'(WAIT_STATES + READ_LATENCY);
  localparam logic [3:0]  WRITE_COUNT   = 4'(WAIT_STATES);
  localparam logic [3:0]  CAPTURE_COUNT = 4'(WAIT_STATES + 1);

  state_e        state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic          in_range_q, in_range_d;
  logic          is_write_q, is_write_d;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mem_en_q, mem_en_d;
  logic [3:0]    mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic [31:0]   req_offset;
  logic          req_in_range;
  logic          req_is_write;
  logic [3:0]    access_count;

  always_comb begin
    // Range is judged on the full 32-bit offset so aliases above the window miss.
    req_offset   = address - BASE_ADDRESS;
    req_in_range = {1'b0, req_offset} < WINDOW_BYTES;
    req_is_write = wstrobe != WSTROBE_NONE;
    access_count = is_write_q ? WRITE_COUNT : READ_COUNT;

    state_d     = state_q;
    count_d     = count_q;
    in_range_d  = in_range_q;
    is_write_d  = is_write_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ready_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 4'b0000;

    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d     = ACCESS;
          in_range_d  = req_in_range;
          is_write_d  = req_is_write;
          mem_addr_d  = AW'(word_index(address, BASE_ADDRESS));
          mem_wdata_d = wdata;
          mem_en_d    = req_in_range;
          mem_we_d    = req_in_range ? wstrobe : 4'b0000;
        end
      end
      ACCESS: begin
        count_d = access_count;
        if (access_count != 4'd0) begin
          state_d = WAIT;
        end else begin
          state_d = RESPOND;
          ready_d = 1'b1;
        end
      end
      WAIT: begin
        // This count value lines up with the cycle the SRAM read data is valid.
        if (!is_write_q && count_q == CAPTURE_COUNT) begin
          rdata_d = in_range_q ? mem_rdata : 32'h0;
        end
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = RESPOND;
          ready_d = 1'b1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= 4'd0;
      in_range_q  <= 1'b0;
      is_write_q  <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= 32'h0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      in_range_q  <= in_range_d;
      is_write_q  <= is_write_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ready     = ready_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_verbus_sram_controller.sv
// ----------------------------------------------------------------------------
// tb_verbus_sram_controller: directed self-checking bench for the SRAM slave
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_verbus_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, valid, sel_b, ovr;
  logic [31:0] address, wdata;
  logic [3:0]  wstrobe;
  logic        valid_a, valid_b;

  assign valid_a = valid & ~sel_b;
  assign valid_b = valid & sel_b;

  // Instance A: default parameters
  logic        ready_a, mem_en_a;
  logic [31:0] rdata_a, mem_wdata_a, model_rdata_a;
  logic [3:0]  mem_we_a;
  logic [11:0] mem_addr_a;

  // Instance B: small window at a non-zero base, extra latency and wait states
  logic        ready_b, mem_en_b;
  logic [31:0] rdata_b, mem_wdata_b, model_rdata_b, dut_rdata_b;
  logic [3:0]  mem_we_b;
  logic [3:0]  mem_addr_b;

  assign dut_rdata_b = ovr ? 32'h5555_AAAA : model_rdata_b;

  verbus_sram_controller u_dut_a (
    .clk(clk), .reset_n(reset_n), .valid(valid_a), .ready(ready_a),
    .address(address), .wstrobe(wstrobe), .wdata(wdata), .rdata(rdata_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(model_rdata_a)
  );

  verbus_sram_model u_sram_a (
    .clk(clk), .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(model_rdata_a)
  );

  verbus_sram_controller #(
    .SIZE_WORDS(16), .BASE_ADDRESS(32'h0000_1000), .READ_LATENCY(2), .WAIT_STATES(3)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .valid(valid_b), .ready(ready_b),
    .address(address), .wstrobe(wstrobe), .wdata(wdata), .rdata(rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(dut_rdata_b)
  );

  verbus_sram_model #(.SIZE_WORDS(16), .READ_LATENCY(2)) u_sram_b (
    .clk(clk), .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(model_rdata_b)
  );

  logic        mon_ready, mon_en;
  logic [31:0] mon_rdata, mon_addr;
  logic [3:0]  mon_we;

  assign mon_ready = sel_b ? ready_b : ready_a;
  assign mon_en    = sel_b ? mem_en_b : mem_en_a;
  assign mon_rdata = sel_b ? rdata_b : rdata_a;
  assign mon_we    = sel_b ? mem_we_b : mem_we_a;
  assign mon_addr  = sel_b ? {28'h0, mem_addr_b} : {20'h0, mem_addr_a};

  int          n_checks = 0;
  int          n_pass   = 0;
  int          t_ready_cyc, t_ready_cnt, t_en_cnt, t_en_cyc, idle_ready_cnt;
  logic [31:0] t_we, t_addr, t_rdata;
  logic [31:0] rd_hist [40];
  logic [9:0]  ready_mask, en_mask;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Issues one request starting in c0, samples every cycle mid-period, and
  // keeps valid high until ready has been seen.
  task automatic run_req(input logic b, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] data, input int ovr_from);
    sel_b = b;
    ovr   = 1'b0;
    @(posedge clk); #1;
    valid = 1'b1; address = addr; wstrobe = strb; wdata = data;
    t_ready_cyc = -1; t_ready_cnt = 0; t_en_cnt = 0; t_en_cyc = -1;
    t_we = 0; t_addr = 0; t_rdata = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (ovr_from >= 0 && cyc >= ovr_from) ovr = 1'b1;
      if (t_ready_cyc >= 0) valid = 1'b0;
      @(negedge clk);
      rd_hist[cyc] = mon_rdata;
      if (mon_en) begin
        t_en_cnt++;
        if (t_en_cyc < 0) begin
          t_en_cyc = cyc; t_we = {28'h0, mon_we}; t_addr = mon_addr;
        end
      end
      if (mon_ready) begin
        t_ready_cnt++;
        if (t_ready_cyc < 0) begin
          t_ready_cyc = cyc; t_rdata = mon_rdata;
        end
      end
      if (t_ready_cyc >= 0 && cyc == t_ready_cyc + 1) break;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    ovr   = 1'b0;
    check_value("ready_seen", {31'h0, t_ready_cyc >= 0}, 32'h1);
  endtask

  initial begin
    reset_n = 1'b0; valid = 1'b0; sel_b = 1'b0; ovr = 1'b0;
    address = 0; wstrobe = 0; wdata = 0;
    repeat (3) @(negedge clk);
    check_value("rst_ready", {31'h0, ready_a}, 32'h0);
    check_value("rst_rdata", rdata_a, 32'h0);
    check_value("rst_mem_en", {31'h0, mem_en_a}, 32'h0);
    check_value("rst_mem_we", {28'h0, mem_we_a}, 32'h0);
    check_value("rst_mem_addr", {20'h0, mem_addr_a}, 32'h0);
    check_value("rst_mem_wdata", mem_wdata_a, 32'h0);
    reset_n = 1'b1;

    run_req(1'b0, 32'h10, 4'hF, 32'hDEAD_BEEF, -1);
    check_value("wr_en_cyc", t_en_cyc, 32'd1);
    check_value("wr_en_cnt", t_en_cnt, 32'd1);
    check_value("wr_we", t_we, 32'hF);
    check_value("wr_addr", t_addr, 32'd4);
    check_value("wr_ready_cyc", t_ready_cyc, 32'd2);
    check_value("wr_ready_cnt", t_ready_cnt, 32'd1);

    run_req(1'b0, 32'h10, 4'h0, 32'h0, -1);
    check_value("rd_ready_cyc", t_ready_cyc, 32'd3);
    check_value("rd_en_cnt", t_en_cnt, 32'd1);
    check_value("rd_data", t_rdata, 32'hDEAD_BEEF);

    run_req(1'b0, 32'h10, 4'b0100, 32'h00AB_0000, -1);
    check_value("bw_we", t_we, 32'h4);
    check_value("bw_rdata_held", t_rdata, 32'hDEAD_BEEF);
    run_req(1'b0, 32'h10, 4'h0, 32'h0, -1);
    check_value("bw_rd_data", t_rdata, 32'hDEAB_BEEF);

    run_req(1'b0, 32'h0, 4'hF, 32'h0BAD_F00D, -1);
    run_req(1'b0, 32'h4000, 4'hF, 32'hFFFF_FFFF, -1);
    check_value("oor_wr_en_cnt", t_en_cnt, 32'd0);
    check_value("oor_wr_ready_cyc", t_ready_cyc, 32'd2);
    run_req(1'b0, 32'h4000, 4'h0, 32'h0, -1);
    check_value("oor_rd_en_cnt", t_en_cnt, 32'd0);
    check_value("oor_rd_ready_cyc", t_ready_cyc, 32'd3);
    check_value("oor_rd_data", t_rdata, 32'h0);
    run_req(1'b0, 32'h0, 4'h0, 32'h0, -1);
    check_value("oor_no_alias", t_rdata, 32'h0BAD_F00D);

    // Back-to-back reads with valid held high across the first ready.
    sel_b = 1'b0;
    @(posedge clk); #1;
    valid = 1'b1; address = 32'h10; wstrobe = 4'h0;
    ready_mask = '0; en_mask = '0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc == 8) valid = 1'b0;
      @(negedge clk);
      ready_mask[cyc] = ready_a;
      en_mask[cyc]    = mem_en_a;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    check_value("b2b_ready_mask", {22'h0, ready_mask}, 32'h088);
    check_value("b2b_en_mask", {22'h0, en_mask}, 32'h022);
    check_value("b2b_no_double_ready", {22'h0, ready_mask & (ready_mask >> 1)}, 32'h0);

    run_req(1'b1, 32'h1008, 4'hF, 32'hCAFE_F00D, -1);
    check_value("b_wr_addr", t_addr, 32'd2);
    check_value("b_wr_ready_cyc", t_ready_cyc, 32'd5);
    run_req(1'b1, 32'h1008, 4'h0, 32'h0, 4);
    check_value("b_rd_en_cyc", t_en_cyc, 32'd1);
    check_value("b_rd_en_cnt", t_en_cnt, 32'd1);
    check_value("b_rd_ready_cyc", t_ready_cyc, 32'd7);
    check_value("b_rd_ready_cnt", t_ready_cnt, 32'd1);
    check_value("b_rd_c3", rd_hist[3], 32'h0);
    check_value("b_rd_c4", rd_hist[4], 32'hCAFE_F00D);
    check_value("b_rd_c6", rd_hist[6], 32'hCAFE_F00D);
    check_value("b_rd_c7", rd_hist[7], 32'hCAFE_F00D);
    run_req(1'b1, 32'h0FFC, 4'h0, 32'h0, -1);
    check_value("b_below_en_cnt", t_en_cnt, 32'd0);
    check_value("b_below_ready_cyc", t_ready_cyc, 32'd7);
    check_value("b_below_data", t_rdata, 32'h0);

    // Reset asserted during ACCESS of a write.
    run_req(1'b0, 32'h20, 4'hF, 32'h1111_2222, -1);
    run_req(1'b0, 32'h10, 4'h0, 32'h0, -1);
    sel_b = 1'b0;
    @(posedge clk); #1;
    valid = 1'b1; address = 32'h20; wstrobe = 4'hF; wdata = 32'h9999_9999;
    @(posedge clk); #1;
    valid = 1'b0;
    check_value("mid_access_en", {31'h0, mem_en_a}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check_value("mid_rst_en", {31'h0, mem_en_a}, 32'h0);
    check_value("mid_rst_we", {28'h0, mem_we_a}, 32'h0);
    check_value("mid_rst_addr", {20'h0, mem_addr_a}, 32'h0);
    check_value("mid_rst_wdata", mem_wdata_a, 32'h0);
    check_value("mid_rst_rdata", rdata_a, 32'h0);
    check_value("mid_rst_ready", {31'h0, ready_a}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle_ready_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready_a) idle_ready_cnt++;
    end
    check_value("post_rst_no_ready", idle_ready_cnt, 32'd0);
    run_req(1'b0, 32'h20, 4'h0, 32'h0, -1);
    check_value("post_rst_data", t_rdata, 32'h1111_2222);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
